// File: rtl/wb_pkg.sv
// Shared constants and types for the MEM->WB stage register.
// Everything here is independent of the stage's width parameters.
package wb_pkg;

   localparam int REG_ZERO = 0;

   typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_skid2.sv
// Generic two-entry skid buffer: head slot feeds the consumer, skid slot absorbs
// one extra beat so in_ready can be a flop with no path from out_ready.
module pipe_skid2
   import wb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [WIDTH-1:0] skid_data,
   output logic             skid_valid,
   output occ_t             count
);

   occ_t             count_q;
   occ_t             count_d;
   logic             in_ready_q;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] skid_q;
   logic             push;
   logic             pop;

   assign out_valid  = (count_q != 2'd0);
   assign push       = in_valid & in_ready_q;
   assign pop        = out_valid & out_ready;

   assign in_ready   = in_ready_q;
   assign head_data  = head_q;
   assign skid_data  = skid_q;
   assign head_valid = out_valid;
   assign skid_valid = (count_q == 2'd2);
   assign count      = count_q;

   // NOTE: assign a default before any branch so every path drives count_d and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   // NOTE: payload registers are reset as well, so the outputs read zero while the buffer is empty after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
         count_q    <= 2'd0;
         in_ready_q <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         count_q    <= count_d;
         in_ready_q <= (count_d < 2'd2);
         // Payload moves are harmless during flush: the count forces them invisible.
         case (count_q)
            2'd0: begin
               if (push) head_q <= in_data;
            end
            2'd1: begin
               if (push && pop)  head_q <= in_data;
               else if (push)    skid_q <= in_data;
            end
            2'd2: begin
               if (pop) head_q <= skid_q;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: skid-buffered writeback beats, output data mux,
// register-zero write suppression and RAW hazard flags for the decode scoreboard.
module wb_stage_reg
   import wb_pkg::*;
#(
   parameter int REG_ID_WIDTH      = 5,
   parameter int DATA_WIDTH        = 64,
   parameter int ZERO_REG_SUPPRESS = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    reg_write_in,
   input  logic                    mem_to_reg_in,
   input  logic [REG_ID_WIDTH-1:0] dest_in,
   input  logic [DATA_WIDTH-1:0]   alu_result_in,
   input  logic [DATA_WIDTH-1:0]   mem_data_in,
   input  logic                    flush_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    reg_write_out,
   output logic                    mem_to_reg_out,
   output logic [REG_ID_WIDTH-1:0] dest_out,
   output logic [DATA_WIDTH-1:0]   wb_data_out,
   input  logic [REG_ID_WIDTH-1:0] src1_in,
   input  logic [REG_ID_WIDTH-1:0] src2_in,
   output logic                    hazard1_out,
   output logic                    hazard2_out,
   output occ_t                    occupancy
);

   typedef struct packed {
      logic                    reg_write;
      logic                    mem_to_reg;
      logic [REG_ID_WIDTH-1:0] dest;
      logic [DATA_WIDTH-1:0]   alu_result;
      logic [DATA_WIDTH-1:0]   mem_data;
   } entry_t;

   entry_t in_entry;
   entry_t head;
   entry_t skid;
   logic   head_valid;
   logic   skid_valid;

   assign in_entry = '{
      reg_write:  reg_write_in,
      mem_to_reg: mem_to_reg_in,
      dest:       dest_in,
      alu_result: alu_result_in,
      mem_data:   mem_data_in
   };

   pipe_skid2 #(
      .WIDTH($bits(entry_t))
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .flush     (flush_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .head_data (head),
      .head_valid(head_valid),
      .skid_data (skid),
      .skid_valid(skid_valid),
      .count     (occupancy)
   );

   // Register zero is hardwired, so writes to it are neither performed nor hazards.
   function automatic logic dest_writable(input logic [REG_ID_WIDTH-1:0] dest);
      return (dest != REG_ID_WIDTH'(REG_ZERO)) || (ZERO_REG_SUPPRESS == 0);
   endfunction

   function automatic logic slot_hit(input entry_t e, input logic v,
                                     input logic [REG_ID_WIDTH-1:0] src);
      return v & e.reg_write & (e.dest == src) & dest_writable(e.dest);
   endfunction

   assign reg_write_out  = head_valid & head.reg_write & dest_writable(head.dest);
   assign mem_to_reg_out = head.mem_to_reg;
   assign dest_out       = head.dest;
   assign wb_data_out    = head.mem_to_reg ? head.mem_data : head.alu_result;

   assign hazard1_out = slot_hit(head, head_valid, src1_in) | slot_hit(skid, skid_valid, src1_in);
   assign hazard2_out = slot_hit(head, head_valid, src2_in) | slot_hit(skid, skid_valid, src2_in);

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: a queue model of the buffer checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_wb_stage_reg;

   localparam int RW  = 5;
   localparam int DW  = 64;
   localparam int ZRS = 1;

   typedef struct {
      logic          rw;
      logic          m2r;
      logic [RW-1:0] dest;
      logic [DW-1:0] alu;
      logic [DW-1:0] mem;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, in_ready;
   logic          reg_write_in, mem_to_reg_in;
   logic [RW-1:0] dest_in;
   logic [DW-1:0] alu_result_in, mem_data_in;
   logic          flush_in;
   logic          out_valid, out_ready;
   logic          reg_write_out, mem_to_reg_out;
   logic [RW-1:0] dest_out;
   logic [DW-1:0] wb_data_out;
   logic [RW-1:0] src1_in, src2_in;
   logic          hazard1_out, hazard2_out;
   logic [1:0]    occupancy;

   int checks = 0;
   int errors = 0;

   beat_t q[$];
   logic  m_ready;
   logic  last_push;

   always #5 clk = ~clk;

   wb_stage_reg #(
      .REG_ID_WIDTH(RW),
      .DATA_WIDTH(DW),
      .ZERO_REG_SUPPRESS(ZRS)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .dest_in(dest_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
      .flush_in(flush_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .dest_out(dest_out), .wb_data_out(wb_data_out),
      .src1_in(src1_in), .src2_in(src2_in),
      .hazard1_out(hazard1_out), .hazard2_out(hazard2_out),
      .occupancy(occupancy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_hazard(input logic [RW-1:0] s);
      logic h = 1'b0;
      foreach (q[i])
         if (q[i].rw && q[i].dest == s && (q[i].dest != 0 || ZRS == 0)) h = 1'b1;
      return h;
   endfunction

   // Reference model: a FIFO of at most two beats plus a registered ready.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_ready   <= 1'b0;
         last_push <= 1'b0;
      end else begin
         if (flush_in) begin
            q.delete();
         end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && m_ready)
               q.push_back('{rw: reg_write_in, m2r: mem_to_reg_in, dest: dest_in,
                             alu: alu_result_in, mem: mem_data_in});
         end
         m_ready   <= (q.size() < 2);
         last_push <= in_valid && m_ready;
      end
   end

   // Compare process: outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (reset_n) begin
         check("in_ready",  in_ready,  m_ready);
         check("out_valid", out_valid, q.size() != 0);
         check("occupancy", occupancy, q.size());
         check("hazard1",   hazard1_out, exp_hazard(src1_in));
         check("hazard2",   hazard2_out, exp_hazard(src2_in));
         if (q.size() != 0) begin
            check("dest_out",       dest_out,       q[0].dest);
            check("mem_to_reg_out", mem_to_reg_out, q[0].m2r);
            check("wb_data_out",    wb_data_out,    q[0].m2r ? q[0].mem : q[0].alu);
            check("reg_write_out",  reg_write_out,  q[0].rw && (q[0].dest != 0 || ZRS == 0));
         end else begin
            check("reg_write_out_empty", reg_write_out, 1'b0);
         end
      end
   end

   // Applies one set of inputs across one rising edge; returns on the next falling edge.
   task automatic drive(input logic v, input logic rw, input logic m2r, input logic [RW-1:0] d,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic fl, input logic ordy);
      #1;
      in_valid      = v;
      reg_write_in  = rw;
      mem_to_reg_in = m2r;
      dest_in       = d;
      alu_result_in = alu;
      mem_data_in   = mem;
      flush_in      = fl;
      out_ready     = ordy;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, ordy);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  in_ready, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_reg_write"}, reg_write_out, 1'b0);
      check({tag, "_mem_to_reg"}, mem_to_reg_out, 1'b0);
      check({tag, "_dest"},      dest_out, 0);
      check({tag, "_wb_data"},   wb_data_out, 0);
      check({tag, "_occupancy"}, occupancy, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0; dest_in = '0;
      alu_result_in = '0; mem_data_in = '0; flush_in = 1'b0; out_ready = 1'b0;
      src1_in = 5'd7; src2_in = 5'd0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", in_ready, 1'b1);

      // Single beat
      drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 64'hdead, 1'b0, 1'b1);
      check("t1_out_valid", out_valid, 1'b1);
      check("t1_dest", dest_out, 5);
      check("t1_wb_data", wb_data_out, 64'h1234);
      check("t1_reg_write", reg_write_out, 1'b1);
      idle(1'b1);

      // Back-pressure: A, B accepted, C held, then drained in order
      drive(1'b1, 1'b1, 1'b1, 5'd1, 64'ha0, 64'ha1, 1'b0, 1'b0);
      check("bp_occ1", occupancy, 1);
      drive(1'b1, 1'b1, 1'b0, 5'd2, 64'hb0, 64'hb1, 1'b0, 1'b0);
      check("bp_occ2", occupancy, 2);
      check("bp_ready0", in_ready, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 5'd3, 64'hc0, 64'hc1, 1'b0, 1'b0);
      check("bp_held_occ", occupancy, 2);
      check("bp_head_a", wb_data_out, 64'ha1);
      drive(1'b1, 1'b0, 1'b0, 5'd3, 64'hc0, 64'hc1, 1'b0, 1'b1);
      check("bp_head_b", dest_out, 2);
      check("bp_occ_after_pop", occupancy, 1);
      drive(1'b1, 1'b0, 1'b0, 5'd3, 64'hc0, 64'hc1, 1'b0, 1'b1);
      check("bp_pushpop_occ", occupancy, 1);
      check("bp_head_c", dest_out, 3);
      idle(1'b1);

      // Hazard and register zero
      drive(1'b1, 1'b1, 1'b0, 5'd7, 64'h77, 64'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 5'd0, 64'h99, 64'h0, 1'b0, 1'b0);
      check("haz1_dest7", hazard1_out, 1'b1);
      check("haz2_dest0", hazard2_out, 1'b0);
      idle(1'b1);
      check("x0_head_valid", out_valid, 1'b1);
      check("x0_reg_write", reg_write_out, 1'b0);

      // Flush at count 2 with a beat offered, then again with it accepted
      drive(1'b1, 1'b1, 1'b0, 5'd9, 64'hf0, 64'h0, 1'b0, 1'b0);
      check("fl_occ2", occupancy, 2);
      drive(1'b1, 1'b1, 1'b0, 5'd10, 64'h610, 64'h0, 1'b1, 1'b0);
      check("fl_occ0", occupancy, 0);
      check("fl_valid0", out_valid, 1'b0);
      check("fl_rw0", reg_write_out, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 5'd10, 64'h610, 64'h0, 1'b1, 1'b1);
      idle(1'b1);
      check("fl_discarded", out_valid, 1'b0);

      // Asynchronous reset at count 2
      drive(1'b1, 1'b1, 1'b0, 5'd11, 64'h11, 64'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 5'd12, 64'h12, 64'h0, 1'b0, 1'b0);
      check("ar_occ2", occupancy, 2);
      #2 reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      #1 reset_n = 1'b1;
      idle(1'b1);
      check("ar_no_stale", out_valid, 1'b0);

      // Random traffic; a refused beat is held stable until accepted
      begin
         logic          v = 1'b0, rw = 1'b0, m2r = 1'b0;
         logic [RW-1:0] d = '0;
         logic [DW-1:0] alu = '0, mem = '0;
         for (int n = 0; n < 400; n++) begin
            if (!(v && !last_push)) begin
               v   = ($urandom_range(0, 3) != 0);
               rw  = $urandom_range(0, 1);
               m2r = $urandom_range(0, 1);
               d   = RW'($urandom_range(0, 7));
               alu = {$urandom, $urandom};
               mem = {$urandom, $urandom};
            end
            src1_in = RW'($urandom_range(0, 7));
            src2_in = RW'($urandom_range(0, 7));
            drive(v, rw, m2r, d, alu, mem, ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) < 7));
         end
      end
      idle(1'b1);
      idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
